// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control and a sideband tag.
// The carry-in is folded into the prefix tree as an extra lowest bit so every carry is a plain group generate.
module ks_adder_pipe #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    input  logic             i_cin,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic [TAG_W-1:0] o_tag
);

    localparam int LEVELS = $clog2(WIDTH);

    // One global enable: the whole pipe advances or the whole pipe holds.
    logic en;
    assign en      = !o_valid || i_ready;
    assign o_ready = en;

    // Pre-stage. Extended vectors: index 0 carries c0 as g[-1] (p = 0), index i+1 is operand bit i.
    logic [WIDTH-1:0] b_x;
    logic [WIDTH-1:0] pre_ps;
    logic             pre_c0;
    logic [WIDTH:0]   pre_g;
    logic [WIDTH:0]   pre_p;

    assign b_x    = i_sub ? ~i_b : i_b;
    assign pre_c0 = i_sub | i_cin;
    assign pre_ps = i_a ^ b_x;
    assign pre_g  = {i_a & b_x, pre_c0};
    assign pre_p  = {pre_ps, 1'b0};

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int SPAN     = 1 << k;
        localparam bit REG_HERE = ((k + 1) % REG_EVERY == 0) && (k < LEVELS - 1);

        logic [WIDTH:0]   in_g, in_p, nx_g, nx_p;
        logic             in_v;
        logic [TAG_W-1:0] in_tag;
        logic [WIDTH-1:0] in_ps;

        logic [WIDTH:0]   out_g, out_p;
        logic             out_v;
        logic [TAG_W-1:0] out_tag;
        logic [WIDTH-1:0] out_ps;

        if (k == 0) begin : g_src
            assign in_g   = pre_g;
            assign in_p   = pre_p;
            assign in_v   = i_valid && en;
            assign in_tag = i_tag;
            assign in_ps  = pre_ps;
        end else begin : g_src
            assign in_g   = g_lvl[k-1].out_g;
            assign in_p   = g_lvl[k-1].out_p;
            assign in_v   = g_lvl[k-1].out_v;
            assign in_tag = g_lvl[k-1].out_tag;
            assign in_ps  = g_lvl[k-1].out_ps;
        end

        // Bits below SPAN are already complete. Bits in [SPAN, 2*SPAN) reach c0 at this level,
        // so only their generate matters (grey cell); higher bits need both (black cell).
        always_comb begin
            nx_g = in_g;
            nx_p = in_p;
            for (int j = SPAN; j <= WIDTH; j++) begin
                nx_g[j] = in_g[j] | (in_p[j] & in_g[j-SPAN]);
                if (j >= 2 * SPAN) begin
                    nx_p[j] = in_p[j] & in_p[j-SPAN];
                end
            end
        end

        if (REG_HERE) begin : g_reg
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    out_v <= 1'b0;
                end else if (en) begin
                    out_v <= in_v;
                end
            end

            // NOTE: data registers are not reset; the valid bit alone qualifies them, which keeps
            // the reset net off the wide datapath.
            always_ff @(posedge i_clk) begin
                if (en) begin
                    out_g   <= nx_g;
                    out_p   <= nx_p;
                    out_tag <= in_tag;
                    out_ps  <= in_ps;
                end
            end
        end else begin : g_comb
            assign out_g   = nx_g;
            assign out_p   = nx_p;
            assign out_v   = in_v;
            assign out_tag = in_tag;
            assign out_ps  = in_ps;
        end
    end

    // Post-stage. The MSB group spans bits [WIDTH-1:0] only, so fold c0 in once more for cout.
    logic [WIDTH:0] fin_g;
    logic           fin_p_msb;
    logic           cout_nx;

    assign fin_g     = g_lvl[LEVELS-1].out_g;
    assign fin_p_msb = g_lvl[LEVELS-1].out_p[WIDTH];
    assign cout_nx   = fin_g[WIDTH] | (fin_p_msb & fin_g[0]);

    // Output data only loads on a valid result so stale stage data never reaches the ports.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_cout  <= 1'b0;
            o_ovf   <= 1'b0;
            o_tag   <= '0;
        end else if (en) begin
            o_valid <= g_lvl[LEVELS-1].out_v;
            if (g_lvl[LEVELS-1].out_v) begin
                o_sum  <= g_lvl[LEVELS-1].out_ps ^ fin_g[WIDTH-1:0];
                o_cout <= cout_nx;
                o_ovf  <= fin_g[WIDTH-1] ^ cout_nx;
                o_tag  <= g_lvl[LEVELS-1].out_tag;
            end
        end
    end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe: a 32-bit instance with a register after every level and an 8-bit
// instance registered every two levels, both checked against an arithmetic reference model.
module tb_ks_adder_pipe;

    localparam int W    = 32;
    localparam int RE   = 1;
    localparam int TW   = 6;
    localparam int LAT  = ($clog2(W) - 1) / RE + 1;
    localparam int W2   = 8;
    localparam int RE2  = 2;
    localparam int LAT2 = ($clog2(W2) - 1) / RE2 + 1;

    typedef struct {
        logic [63:0]   sum;
        logic          cout;
        logic          ovf;
        logic [TW-1:0] tag;
        int            acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    bit lat_strict  = 1'b1;

    // 32-bit instance
    logic          valid, ready_o, sub, cin, vout, ready_i, cout, ovf;
    logic [W-1:0]  a, b, sum;
    logic [TW-1:0] tag, tag_o;

    ks_adder_pipe #(.WIDTH(W), .REG_EVERY(RE), .TAG_W(TW)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready_o),
        .i_a(a), .i_b(b), .i_sub(sub), .i_cin(cin), .i_tag(tag),
        .o_valid(vout), .i_ready(ready_i), .o_sum(sum), .o_cout(cout),
        .o_ovf(ovf), .o_tag(tag_o)
    );

    // 8-bit instance
    logic          valid2, ready_o2, sub2, cin2, vout2, ready_i2, cout2, ovf2;
    logic [W2-1:0] a2, b2, sum2;
    logic [TW-1:0] tag2, tag_o2;

    ks_adder_pipe #(.WIDTH(W2), .REG_EVERY(RE2), .TAG_W(TW)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid2), .o_ready(ready_o2),
        .i_a(a2), .i_b(b2), .i_sub(sub2), .i_cin(cin2), .i_tag(tag2),
        .o_valid(vout2), .i_ready(ready_i2), .o_sum(sum2), .o_cout(cout2),
        .o_ovf(ovf2), .o_tag(tag_o2)
    );

    exp_t sb[$];
    exp_t sb2[$];

    function automatic exp_t model(int w, logic [63:0] x, logic [63:0] y, logic s, logic ci,
                                   logic [TW-1:0] t, int acc);
        logic [63:0] mask, xx, yy;
        logic [64:0] r;
        exp_t        e;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        xx     = x & mask;
        yy     = (s ? ~y : y) & mask;
        r      = {1'b0, xx} + {1'b0, yy} + 65'(s | ci);
        e.sum  = r[63:0] & mask;
        e.cout = r[w];
        e.ovf  = (xx[w-1] == yy[w-1]) && (e.sum[w-1] != xx[w-1]);
        e.tag  = t;
        e.acc  = acc;
        return e;
    endfunction

    // Scoreboard for the 32-bit instance: push on acceptance, pop on each output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            vectors++;
            if (ready_o !== (!vout || ready_i)) begin
                miscompares++;
                $display("FAIL o_ready: got %b expected %b (o_valid=%b i_ready=%b)",
                         ready_o, !vout || ready_i, vout, ready_i);
            end
            if (vout && ready_i) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_output: o_valid=1 with nothing outstanding, sum=%h tag=%0d",
                             sum, tag_o);
                end else begin
                    e = sb.pop_front();
                    if ({sum, cout, ovf, tag_o} !== {e.sum[W-1:0], e.cout, e.ovf, e.tag}) begin
                        miscompares++;
                        $display("FAIL result: got sum=%h cout=%b ovf=%b tag=%0d expected sum=%h cout=%b ovf=%b tag=%0d",
                                 sum, cout, ovf, tag_o, e.sum[W-1:0], e.cout, e.ovf, e.tag);
                    end
                    if (lat_strict && (cyc - e.acc != LAT)) begin
                        miscompares++;
                        $display("FAIL latency: got %0d expected %0d", cyc - e.acc, LAT);
                    end
                end
            end
            if (valid && ready_o)
                sb.push_back(model(W, 64'(a), 64'(b), sub, cin, tag, cyc));
        end
    end

    // Scoreboard for the 8-bit instance; downstream always ready, so latency is always exact.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (vout2 && ready_i2) begin
                vectors++;
                if (sb2.size() == 0) begin
                    miscompares++;
                    $display("FAIL w8_spurious_output: sum=%h tag=%0d", sum2, tag_o2);
                end else begin
                    e = sb2.pop_front();
                    if ({sum2, cout2, ovf2, tag_o2} !== {e.sum[W2-1:0], e.cout, e.ovf, e.tag}
                        || (cyc - e.acc != LAT2)) begin
                        miscompares++;
                        $display("FAIL w8_result: got sum=%h cout=%b ovf=%b tag=%0d lat=%0d expected sum=%h cout=%b ovf=%b tag=%0d lat=%0d",
                                 sum2, cout2, ovf2, tag_o2, cyc - e.acc,
                                 e.sum[W2-1:0], e.cout, e.ovf, e.tag, LAT2);
                    end
                end
            end
            if (valid2 && ready_o2)
                sb2.push_back(model(W2, 64'(a2), 64'(b2), sub2, cin2, tag2, cyc));
        end
    end

    task automatic drive(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                         input logic xc, input logic [TW-1:0] xt);
        int n;
        @(posedge clk); #1;
        a = xa; b = xb; sub = xs; cin = xc; tag = xt; valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            vectors++;
            miscompares++;
            $display("FAIL drive_timeout: o_ready got 0 for %0d cycles, expected 1", n);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || sb2.size() != 0) && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        vectors++;
        if (sb.size() != 0 || sb2.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: outstanding got %0d/%0d expected 0/0", sb.size(), sb2.size());
        end
    endtask

    // Single vector into an empty pipe; counts rising edges from acceptance to o_valid.
    task automatic one_shot(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                            input logic xc, input logic [TW-1:0] xt);
        int lat;
        drive(xa, xb, xs, xc, xt);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            if (lat == 0) valid = 1'b0;
            lat++;
            if (vout) break;
        end
        vectors++;
        if (lat != LAT) begin
            miscompares++;
            $display("FAIL first_latency: got %0d expected %0d", lat, LAT);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; ready_i = 1'b1; valid2 = 1'b0; ready_i2 = 1'b1;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0; tag = '0;
        a2 = '0; b2 = '0; sub2 = 1'b0; cin2 = 1'b0; tag2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({vout, cout, ovf, tag_o, sum} !== '0 || ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b sum=%h cout=%b ovf=%b tag=%0d ready=%b expected all 0, ready=1",
                     vout, sum, cout, ovf, tag_o, ready_o);
        end
        vectors++;
        if ({vout2, cout2, ovf2, tag_o2, sum2} !== '0 || ready_o2 !== 1'b1) begin
            miscompares++;
            $display("FAIL w8_reset_state: got valid=%b sum=%h ready=%b expected 0/0/1", vout2, sum2, ready_o2);
        end
    endtask

    task automatic test_basic();
        lat_strict = 1'b1;
        one_shot(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 6'd7);
        wait_drain();
    endtask

    task automatic test_boundaries();
        logic [W-1:0]  ta [10];
        logic [W-1:0]  tb [10];
        logic [1:0]    tm [10];
        ta = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0003, 32'h1234_5678,
               32'h1234_5678, 32'h0000_0003, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        tb = '{32'h0000_0003, 32'h0000_0000, 32'h0000_0001, 32'h0000_0005, 32'h1234_5678,
               32'h1234_5678, 32'h0000_0005, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
        // {sub, cin}
        tm = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b10, 2'b10};
        lat_strict = 1'b1;
        for (int i = 0; i < 10; i++)
            drive(ta[i], tb[i], tm[i][1], tm[i][0], 6'(i + 20));
        idle();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        bit done;
        lat_strict = 1'b0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    drive(32'h1000_0000 * i + 32'h0101, 32'h0F0F_0F0F - i, i[0], i[1], 6'(40 + i));
                idle();
                done = 1'b1;
            end
            begin
                repeat (7) @(posedge clk);
                #1 ready_i = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    vectors++;
                    if (ready_o !== 1'b0) begin
                        miscompares++;
                        $display("FAIL stall_ready: got %b expected 0 (stall cycle %0d)", ready_o, i);
                    end
                    if (i < 2) begin
                        @(posedge clk); #1;
                    end
                end
                @(posedge clk); #1;
                ready_i = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_reset_midflight();
        lat_strict = 1'b1;
        for (int i = 0; i < 3; i++)
            drive(32'hAAAA_0000 + i, 32'h5555_0000, 1'b0, 1'b0, 6'(50 + i));
        @(posedge clk); #1;
        valid = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if (vout !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_flush: o_valid got %b expected 0 at cycle %0d after reset", vout, i);
            end
        end
        one_shot(32'hDEAD_BEEF, 32'h0000_1111, 1'b1, 1'b0, 6'd63);
        wait_drain();
    endtask

    task automatic test_random();
        bit done;
        lat_strict = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            drive($urandom, (i % 5 == 0) ? a : 32'($urandom), 1'($urandom), 1'($urandom), 6'($urandom));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        wait_drain();
        lat_strict = 1'b0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 500; i++)
                    drive($urandom, $urandom, 1'($urandom), 1'($urandom), 6'($urandom));
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    ready_i = ($urandom_range(0, 2) != 0);
                end
                ready_i = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_w8_sweep();
        for (int i = 0; i < 1200; i++) begin
            @(posedge clk); #1;
            valid2 = ($urandom_range(0, 4) != 0);
            a2     = 8'($urandom);
            b2     = (i % 7 == 0) ? a2 : 8'($urandom);
            sub2   = 1'($urandom);
            cin2   = 1'($urandom);
            tag2   = 6'($urandom);
        end
        @(posedge clk); #1;
        valid2 = 1'b0;
        wait_drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        test_w8_sweep();
        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
